// File: rtl/st_port_responder_pkg.sv
// Shared types and constants for the data-cache store-port responder.
// One buffered store is an st_port_entry_t; drain addresses are word-aligned.
package st_port_responder_pkg;

   localparam int unsigned PKG_PLEN    = 56;
   localparam int unsigned PKG_XLEN    = 64;
   localparam int unsigned PKG_BEW     = PKG_XLEN / 8;
   localparam int unsigned ALIGN_SHIFT = $clog2(PKG_BEW);

   typedef struct packed {
      logic [PKG_PLEN-1:0] addr;
      logic [PKG_XLEN-1:0] wdata;
      logic [PKG_BEW-1:0]  be;
      logic [1:0]          size;
   } st_port_entry_t;

   localparam logic [0:0] DRAIN_IDLE = 1'b0;
   localparam logic [0:0] DRAIN_REQ  = 1'b1;

   // Clear the byte-offset bits so the downstream port only sees word addresses.
   function automatic logic [PKG_PLEN-1:0] align_addr(input logic [PKG_PLEN-1:0] addr);
      logic [PKG_PLEN-1:0] a;
      a = addr;
      a[ALIGN_SHIFT-1:0] = {ALIGN_SHIFT{1'b0}};
      return a;
   endfunction

endpackage

// File: rtl/st_port_fifo.sv
// DEPTH-entry store FIFO; exposes head, next-head, occupancy and per-entry
// valid/address so the top can drain in order and check page-offset hazards.
module st_port_fifo
   import st_port_responder_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                                clk_i,
   input  logic                                rst_ni,
   input  logic                                push_i,
   input  st_port_entry_t                      entry_i,
   input  logic                                pop_i,
   output logic                                full_o,
   output logic                                empty_o,
   output logic [$clog2(DEPTH):0]              count_o,
   output st_port_entry_t                      head_o,
   output st_port_entry_t                      head_next_o,
   output logic [DEPTH-1:0]                    valid_o,
   output logic [DEPTH-1:0][PKG_PLEN-1:0]      addr_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   st_port_entry_t    mem_r [DEPTH];
   logic [PW-1:0]     wptr_r;
   logic [PW-1:0]     rptr_r;
   logic [PW:0]       count_r;
   logic [DEPTH-1:0]  valid_r;

   // Storage, pointers and occupancy; the caller never pushes when full or pops when empty.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {$bits(st_port_entry_t){1'b0}};
         end
         wptr_r  <= {PW{1'b0}};
         rptr_r  <= {PW{1'b0}};
         count_r <= {(PW+1){1'b0}};
         valid_r <= {DEPTH{1'b0}};
      end else begin
         if (push_i) begin
            mem_r[wptr_r]   <= entry_i;
            valid_r[wptr_r] <= 1'b1;
            wptr_r          <= wptr_r + PW'(1);
         end
         if (pop_i) begin
            valid_r[rptr_r] <= 1'b0;
            rptr_r          <= rptr_r + PW'(1);
         end
         case ({push_i, pop_i})
            2'b10:   count_r <= count_r + (PW+1)'(1);
            2'b01:   count_r <= count_r - (PW+1)'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign full_o      = (count_r == (PW+1)'(DEPTH));
   assign empty_o     = (count_r == (PW+1)'(0));
   assign count_o     = count_r;
   assign head_o      = mem_r[rptr_r];
   assign head_next_o = mem_r[rptr_r + PW'(1)];
   assign valid_o     = valid_r;

   for (genvar g = 0; g < DEPTH; g++) begin : g_addr
      assign addr_o[g] = mem_r[g].addr;
   end

endmodule

// File: rtl/st_port_responder.sv
// Store-port responder: grants and acknowledges store-buffer writes, queues
// them, and drains them in order to a req/gnt memory port.
module st_port_responder
   import st_port_responder_pkg::*;
#(
   parameter int unsigned PLEN    = PKG_PLEN,
   parameter int unsigned XLEN    = PKG_XLEN,
   parameter int unsigned DEPTH   = 4,
   parameter int unsigned ACK_LAT = 1
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              data_req_i,
   input  logic              data_we_i,
   input  logic [PLEN-1:0]   address_i,
   input  logic [XLEN-1:0]   data_wdata_i,
   input  logic [XLEN/8-1:0] data_be_i,
   input  logic [1:0]        data_size_i,
   output logic              data_gnt_o,
   output logic              data_rvalid_o,
   input  logic [11:0]       page_offset_i,
   output logic              page_offset_matches_o,
   output logic              empty_o,
   output logic              mem_req_o,
   output logic [PLEN-1:0]   mem_addr_o,
   output logic [XLEN-1:0]   mem_wdata_o,
   output logic [XLEN/8-1:0] mem_be_o,
   input  logic              mem_gnt_i
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic                          gnt_s;
   logic                          pop_s;
   logic                          full_s;
   logic                          fifo_empty_s;
   logic [CW-1:0]                 count_s;
   st_port_entry_t                entry_s;
   st_port_entry_t                head_s;
   st_port_entry_t                head_next_s;
   logic [DEPTH-1:0]              valid_s;
   logic [DEPTH-1:0][PLEN-1:0]    entry_addr_s;
   logic                          match_s;
   logic                          unused_s;

   logic [ACK_LAT-1:0]            ack_pipe_r;
   logic [0:0]                    state_r;
   logic                          mem_req_r;
   st_port_entry_t                out_r;

   // Full is judged on the pre-pop count; nothing is granted while held in reset.
   assign gnt_s = rst_ni & data_req_i & data_we_i & ~full_s;
   assign pop_s = (state_r == DRAIN_REQ) & mem_gnt_i;

   // Pack the incoming store into a FIFO entry.
   always_comb begin
      entry_s       = {$bits(st_port_entry_t){1'b0}};
      entry_s.addr  = address_i;
      entry_s.wdata = data_wdata_i;
      entry_s.be    = data_be_i;
      entry_s.size  = data_size_i;
   end

   st_port_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (gnt_s),
      .entry_i     (entry_s),
      .pop_i       (pop_s),
      .full_o      (full_s),
      .empty_o     (fifo_empty_s),
      .count_o     (count_s),
      .head_o      (head_s),
      .head_next_o (head_next_s),
      .valid_o     (valid_s),
      .addr_o      (entry_addr_s)
   );

   // Delay every grant by ACK_LAT cycles to form the write acknowledge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ack_pipe_r <= {ACK_LAT{1'b0}};
      end else begin
         ack_pipe_r[0] <= gnt_s;
         for (int i = 1; i < ACK_LAT; i++) begin
            ack_pipe_r[i] <= ack_pipe_r[i-1];
         end
      end
   end

   // Drain FSM: present the head downstream, retire it on mem_gnt_i and
   // chain straight into the next entry (or the bypassed push) without a bubble.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_r   <= DRAIN_IDLE;
         mem_req_r <= 1'b0;
         out_r     <= {$bits(st_port_entry_t){1'b0}};
      end else begin
         case (state_r)
            DRAIN_IDLE: begin
               if (!fifo_empty_s) begin
                  out_r     <= head_s;
                  mem_req_r <= 1'b1;
                  state_r   <= DRAIN_REQ;
               end else begin
                  mem_req_r <= 1'b0;
               end
            end
            DRAIN_REQ: begin
               if (mem_gnt_i) begin
                  if (count_s > CW'(1)) begin
                     out_r <= head_next_s;
                  end else if (gnt_s) begin
                     out_r <= entry_s;
                  end else begin
                     mem_req_r <= 1'b0;
                     state_r   <= DRAIN_IDLE;
                  end
               end else begin
                  mem_req_r <= 1'b1;
               end
            end
            default: begin
               mem_req_r <= 1'b0;
               state_r   <= DRAIN_IDLE;
            end
         endcase
      end
   end

   // The in-flight head stays valid until retired, so it still flags a hazard.
   always_comb begin
      match_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_s[i] && (entry_addr_s[i][11:3] == page_offset_i[11:3])) begin
            match_s = 1'b1;
         end else begin
            match_s = match_s;
         end
      end
   end

   assign data_gnt_o            = gnt_s;
   assign data_rvalid_o         = ack_pipe_r[ACK_LAT-1];
   assign page_offset_matches_o = match_s;
   assign empty_o               = fifo_empty_s & (state_r == DRAIN_IDLE);
   assign mem_req_o             = mem_req_r;
   assign mem_addr_o            = align_addr(out_r.addr);
   assign mem_wdata_o           = out_r.wdata;
   assign mem_be_o              = out_r.be;

   assign unused_s = ^{out_r.size, page_offset_i[2:0], entry_addr_s};

endmodule

// File: tb/tb_st_port_responder.sv
// Self-checking bench for st_port_responder: vector table plus a cycle monitor
// that models occupancy/drain and scoreboards downstream writes in order.
module tb_st_port_responder;
   import st_port_responder_pkg::*;

   localparam int unsigned PLEN  = 56;
   localparam int unsigned XLEN  = 64;
   localparam int unsigned BEW   = 8;
   localparam int unsigned DEPTH = 4;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b1;
   logic              data_req_i = 1'b0;
   logic              data_we_i = 1'b0;
   logic [PLEN-1:0]   address_i = '0;
   logic [XLEN-1:0]   data_wdata_i = '0;
   logic [BEW-1:0]    data_be_i = '0;
   logic [1:0]        data_size_i = 2'd3;
   logic              data_gnt_o;
   logic              data_rvalid_o;
   logic [11:0]       page_offset_i = 12'h000;
   logic              page_offset_matches_o;
   logic              empty_o;
   logic              mem_req_o;
   logic [PLEN-1:0]   mem_addr_o;
   logic [XLEN-1:0]   mem_wdata_o;
   logic [BEW-1:0]    mem_be_o;
   logic              mem_gnt_i = 1'b0;

   st_port_responder #(
      .PLEN(PLEN), .XLEN(XLEN), .DEPTH(DEPTH), .ACK_LAT(1)
   ) dut (
      .clk_i                 (clk_i),
      .rst_ni                (rst_ni),
      .data_req_i            (data_req_i),
      .data_we_i             (data_we_i),
      .address_i             (address_i),
      .data_wdata_i          (data_wdata_i),
      .data_be_i             (data_be_i),
      .data_size_i           (data_size_i),
      .data_gnt_o            (data_gnt_o),
      .data_rvalid_o         (data_rvalid_o),
      .page_offset_i         (page_offset_i),
      .page_offset_matches_o (page_offset_matches_o),
      .empty_o               (empty_o),
      .mem_req_o             (mem_req_o),
      .mem_addr_o            (mem_addr_o),
      .mem_wdata_o           (mem_wdata_o),
      .mem_be_o              (mem_be_o),
      .mem_gnt_i             (mem_gnt_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [PLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [BEW-1:0]  be;
   } wr_t;

   typedef struct {
      logic            req;
      logic            we;
      logic            mgnt;
      logic [PLEN-1:0] addr;
      logic [XLEN-1:0] data;
      logic [BEW-1:0]  be;
      logic            exp_gnt;
   } vec_t;

   wr_t  sb[$];
   vec_t vecs[$];
   int   n_checks = 0;
   int   n_pass = 0;

   int   m_count = 0;
   logic m_req = 1'b0;
   logic m_prev_gnt = 1'b0;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   function automatic vec_t mk(input logic req, input logic we, input logic mg,
                               input logic [PLEN-1:0] a, input logic [XLEN-1:0] d,
                               input logic [BEW-1:0] be, input logic eg);
      vec_t v;
      v.req = req; v.we = we; v.mgnt = mg; v.addr = a; v.data = d; v.be = be; v.exp_gnt = eg;
      return v;
   endfunction

   // Cycle monitor: occupancy/drain model, ack timing and in-order write scoreboard.
   always @(negedge clk_i) begin : monitor
      logic exp_gnt;
      logic pop;
      int   new_count;
      wr_t  w;
      if (!rst_ni) begin
         check("rst_gnt", data_gnt_o, 1'b0);
         check("rst_rvalid", data_rvalid_o, 1'b0);
         check("rst_mem_req", mem_req_o, 1'b0);
         check("rst_empty", empty_o, 1'b1);
         m_count = 0; m_req = 1'b0; m_prev_gnt = 1'b0;
         sb.delete();
      end else begin
         exp_gnt = data_req_i & data_we_i & (m_count < DEPTH);
         check("mon_gnt", data_gnt_o, exp_gnt);
         check("mon_rvalid", data_rvalid_o, m_prev_gnt);
         check("mon_mem_req", mem_req_o, m_req);
         check("mon_empty", empty_o, (m_count == 0) && !m_req);
         pop = m_req & mem_gnt_i;
         if (pop) begin
            if (sb.size() == 0) begin
               check("sb_nonempty", sb.size(), 1);
            end else begin
               w = sb.pop_front();
               check("mem_addr", mem_addr_o, w.addr);
               check("mem_wdata", mem_wdata_o, w.data);
               check("mem_be", mem_be_o, w.be);
            end
         end
         if (exp_gnt) begin
            w.addr = {address_i[PLEN-1:3], 3'b000};
            w.data = data_wdata_i;
            w.be   = data_be_i;
            sb.push_back(w);
         end
         new_count = m_count + int'(exp_gnt) - int'(pop);
         if (!m_req) m_req = (m_count > 0);
         else if (pop) m_req = (new_count > 0);
         m_count = new_count;
         m_prev_gnt = exp_gnt;
      end
   end

   task automatic apply(input vec_t v, input string name);
      @(posedge clk_i); #1;
      data_req_i = v.req; data_we_i = v.we; mem_gnt_i = v.mgnt;
      address_i = v.addr; data_wdata_i = v.data; data_be_i = v.be;
      @(negedge clk_i);
      check(name, data_gnt_o, v.exp_gnt);
   endtask

   task automatic wait_drain();
      int k;
      k = 0;
      @(posedge clk_i); #1;
      data_req_i = 1'b0; mem_gnt_i = 1'b1;
      @(negedge clk_i);
      while (!empty_o && k < 20) begin
         @(negedge clk_i);
         k++;
      end
      check("drain_done", empty_o, 1'b1);
      check("sb_left", sb.size(), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog timeout");
   end

   initial begin
      int s_stream, s_we0, s_fill, s_rst;

      s_stream = vecs.size();
      for (int i = 0; i < 8; i++)
         vecs.push_back(mk(1'b1, 1'b1, 1'b1, 56'h1000 + 56'(i * 9), {$urandom(), $urandom()}, 8'(8'hFF << (i % 4)), 1'b1));
      s_we0 = vecs.size();
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1'b1, 1'b0, 1'b1, 56'h2000 + 56'(i * 8), {$urandom(), $urandom()}, 8'hFF, 1'b0));
      s_fill = vecs.size();
      for (int i = 0; i < 4; i++)
         vecs.push_back(mk(1'b1, 1'b1, 1'b0, 56'h3000 + 56'(i * 8), {$urandom(), $urandom()}, 8'(8'h0F + i), 1'b1));
      for (int i = 0; i < 2; i++)
         vecs.push_back(mk(1'b1, 1'b1, 1'b0, 56'h3040, 64'hEEEE_0000_EEEE_0005, 8'hF0, 1'b0));
      s_rst = vecs.size();
      for (int i = 0; i < 3; i++)
         vecs.push_back(mk(1'b1, 1'b1, 1'b0, 56'h4000 + 56'(i * 8), {$urandom(), $urandom()}, 8'hFF, 1'b1));

      // Reset state
      #2 rst_ni = 1'b0;
      repeat (3) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      @(negedge clk_i);
      check("reset_empty", empty_o, 1'b1);
      check("reset_mem_req", mem_req_o, 1'b0);
      check("reset_rvalid", data_rvalid_o, 1'b0);
      check("reset_match", page_offset_matches_o, 1'b0);
      check("reset_mem_addr", mem_addr_o, '0);
      check("reset_mem_wdata", mem_wdata_o, '0);

      // Single write with mem_gnt_i held high
      apply(mk(1'b1, 1'b1, 1'b1, 56'h8000_0010, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1), "single_gnt");
      @(posedge clk_i); #1 data_req_i = 1'b0;
      @(negedge clk_i);
      check("single_rvalid", data_rvalid_o, 1'b1);
      check("single_no_req_yet", mem_req_o, 1'b0);
      @(negedge clk_i);
      check("single_mem_req", mem_req_o, 1'b1);
      check("single_mem_addr", mem_addr_o, 56'h8000_0010);
      @(negedge clk_i);
      check("single_empty", empty_o, 1'b1);

      // Page-offset hazard while an entry is pending, then retired
      page_offset_i = 12'h010;
      apply(mk(1'b1, 1'b1, 1'b0, 56'h8000_0010, 64'h1111_2222_3333_4444, 8'h3C, 1'b1), "match_push");
      @(posedge clk_i); #1 data_req_i = 1'b0;
      @(negedge clk_i);
      check("match_pending", page_offset_matches_o, 1'b1);
      page_offset_i = 12'h018; #1;
      check("match_other_word", page_offset_matches_o, 1'b0);
      page_offset_i = 12'h017; #1;
      check("match_low_bits_ignored", page_offset_matches_o, 1'b1);
      page_offset_i = 12'h010;
      @(posedge clk_i); #1 mem_gnt_i = 1'b1;
      @(negedge clk_i);
      check("match_inflight", page_offset_matches_o, 1'b1);
      @(posedge clk_i); #1 mem_gnt_i = 1'b0;
      @(negedge clk_i);
      check("match_cleared", page_offset_matches_o, 1'b0);

      // Streaming: one grant, ack and drain per cycle
      for (int i = s_stream; i < s_we0; i++) begin
         apply(vecs[i], "stream_gnt");
         if (i > s_stream) check("stream_rvalid", data_rvalid_o, 1'b1);
         if (i > s_stream + 1) check("stream_mem_req", mem_req_o, 1'b1);
      end
      wait_drain();

      // Write-enable low is never granted
      for (int i = s_we0; i < s_fill; i++) apply(vecs[i], "we0_gnt");
      @(posedge clk_i); #1 data_req_i = 1'b0;
      @(negedge clk_i);
      check("we0_rvalid", data_rvalid_o, 1'b0);
      check("we0_empty", empty_o, 1'b1);

      // Fill to DEPTH with the port stalled; the 5th request waits
      for (int i = s_fill; i < s_rst; i++) apply(vecs[i], "fill_gnt");
      @(posedge clk_i); #1 mem_gnt_i = 1'b1;
      @(negedge clk_i);
      check("full_pop_gnt", data_gnt_o, 1'b0);
      check("full_mem_req", mem_req_o, 1'b1);
      @(posedge clk_i); #1 mem_gnt_i = 1'b0;
      @(negedge clk_i);
      check("resume_gnt", data_gnt_o, 1'b1);
      wait_drain();

      // Asynchronous reset with entries pending and a request in flight
      for (int i = s_rst; i < vecs.size(); i++) apply(vecs[i], "rst_fill_gnt");
      page_offset_i = 12'h008;
      @(posedge clk_i); #1;
      check("pre_rst_rvalid", data_rvalid_o, 1'b1);
      check("pre_rst_mem_req", mem_req_o, 1'b1);
      check("pre_rst_match", page_offset_matches_o, 1'b1);
      rst_ni = 1'b0; #1;
      check("async_rst_mem_req", mem_req_o, 1'b0);
      check("async_rst_rvalid", data_rvalid_o, 1'b0);
      check("async_rst_gnt", data_gnt_o, 1'b0);
      check("async_rst_match", page_offset_matches_o, 1'b0);
      @(posedge clk_i); #1 data_req_i = 1'b0;
      @(posedge clk_i); #1 rst_ni = 1'b1;
      @(negedge clk_i);
      check("post_rst_empty", empty_o, 1'b1);
      check("post_rst_mem_req", mem_req_o, 1'b0);
      @(negedge clk_i);
      check("post_rst_rvalid", data_rvalid_o, 1'b0);
      check("post_rst_empty2", empty_o, 1'b1);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
